// File: rtl/sma_cross_signal.sv
// Crossover detector on fast/slow moving averages with a one-entry BUY/SELL output buffer.
// Optional trade statistics counters are enabled by defining SMA_CROSS_STATS_EN.
module sma_cross_signal #(
  parameter int unsigned            DATA_WIDTH = 64,
  parameter int unsigned            WARMUP     = 4,
  parameter logic [DATA_WIDTH-1:0]  HYST       = '0
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [DATA_WIDTH-1:0] fast_avg_i,
  input  logic [DATA_WIDTH-1:0] slow_avg_i,
  input  logic                  avg_valid_i,
  output logic                  sig_valid_o,
  output logic                  sig_side_o,
  output logic [DATA_WIDTH-1:0] sig_price_o,
  input  logic                  sig_ready_i,
  output logic                  overflow_o,
`ifdef SMA_CROSS_STATS_EN
  output logic [31:0]           buy_count_o,
  output logic [31:0]           sell_count_o,
`endif
  output logic [1:0]            state_o
);

  // state  | meaning
  // WARMUP | slow average still filling, samples only counted
  // FLAT   | warm, no relation established yet
  // ABOVE  | fast above slow by more than HYST
  // BELOW  | fast below slow by more than HYST
  typedef enum logic [1:0] {
    S_WARMUP = 2'd0,
    S_FLAT   = 2'd1,
    S_ABOVE  = 2'd2,
    S_BELOW  = 2'd3
  } state_e;

  localparam int unsigned     CW        = (WARMUP < 2) ? 1 : $clog2(WARMUP);
  localparam logic [CW-1:0]   WARM_LAST = CW'((WARMUP == 0) ? 0 : WARMUP - 1);
  localparam state_e          RST_STATE = (WARMUP == 0) ? S_FLAT : S_WARMUP;

  state_e                  state_q, state_d;
  logic [CW-1:0]           warm_q, warm_d;
  logic                    sig_valid_q, sig_valid_d;
  logic                    sig_side_q, sig_side_d;
  logic [DATA_WIDTH-1:0]   sig_price_q, sig_price_d;
  logic                    overflow_q, overflow_d;

  logic [DATA_WIDTH:0]     fast_x, slow_x, hyst_x;
  logic                    up, dn, emit, emit_side, xfer;

  // One extra bit so adding the margin can never wrap.
  assign fast_x = {1'b0, fast_avg_i};
  assign slow_x = {1'b0, slow_avg_i};
  assign hyst_x = {1'b0, HYST};
  assign up     = fast_x > (slow_x + hyst_x);
  assign dn     = (fast_x + hyst_x) < slow_x;
  assign xfer   = sig_valid_q & sig_ready_i;

  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    emit      = 1'b0;
    emit_side = 1'b0;
    if (avg_valid_i) begin
      unique case (state_q)
        S_WARMUP: begin
          if (warm_q == WARM_LAST) state_d = S_FLAT;
          else                     warm_d  = warm_q + 1'b1;
        end
        S_FLAT: begin
          if (up)      state_d = S_ABOVE;
          else if (dn) state_d = S_BELOW;
        end
        S_ABOVE: begin
          if (dn) begin
            state_d   = S_BELOW;
            emit      = 1'b1;
            emit_side = 1'b0;
          end
        end
        S_BELOW: begin
          if (up) begin
            state_d   = S_ABOVE;
            emit      = 1'b1;
            emit_side = 1'b1;
          end
        end
        default: state_d = RST_STATE;
      endcase
    end
  end

  always_comb begin
    sig_valid_d = sig_valid_q;
    sig_side_d  = sig_side_q;
    sig_price_d = sig_price_q;
    overflow_d  = 1'b0;
    if (emit) begin
      sig_valid_d = 1'b1;
      sig_side_d  = emit_side;
      sig_price_d = fast_avg_i;
      overflow_d  = sig_valid_q & ~sig_ready_i;
    end else if (xfer) begin
      sig_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= RST_STATE;
      warm_q      <= '0;
      sig_valid_q <= 1'b0;
      sig_side_q  <= 1'b0;
      sig_price_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      sig_valid_q <= sig_valid_d;
      sig_side_q  <= sig_side_d;
      sig_price_q <= sig_price_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sig_valid_o = sig_valid_q;
  assign sig_side_o  = sig_side_q;
  assign sig_price_o = sig_price_q;
  assign overflow_o  = overflow_q;
  assign state_o     = state_q;

`ifdef SMA_CROSS_STATS_EN
  logic [31:0] buy_count_q, buy_count_d;
  logic [31:0] sell_count_q, sell_count_d;

  // Only signals actually handed to the consumer are counted.
  always_comb begin
    buy_count_d  = buy_count_q;
    sell_count_d = sell_count_q;
    if (xfer && sig_side_q && (buy_count_q != 32'hFFFF_FFFF))
      buy_count_d = buy_count_q + 32'd1;
    if (xfer && !sig_side_q && (sell_count_q != 32'hFFFF_FFFF))
      sell_count_d = sell_count_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      buy_count_q  <= '0;
      sell_count_q <= '0;
    end else begin
      buy_count_q  <= buy_count_d;
      sell_count_q <= sell_count_d;
    end
  end

  assign buy_count_o  = buy_count_q;
  assign sell_count_o = sell_count_q;
`endif

endmodule

// File: tb/tb_sma_cross_signal.sv
// Bench for sma_cross_signal: directed vector table, hand-written corner sequences and
// randomized traffic against a reference model; two instances (HYST=0 and HYST=2).
module tb_sma_cross_signal;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] fast = '0;
  logic [63:0] slow = '0;
  logic        av = 1'b0;
  logic        ready = 1'b0;

  logic [1:0]  vld_w, side_w, ovf_w;
  logic [63:0] price_w [2];
  logic [1:0]  st_w [2];
`ifdef SMA_CROSS_STATS_EN
  logic [31:0] buys_w [2];
  logic [31:0] sells_w [2];
`endif

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sma_cross_signal #(.DATA_WIDTH(64), .WARMUP(4), .HYST(64'd0)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .fast_avg_i(fast), .slow_avg_i(slow),
    .avg_valid_i(av), .sig_valid_o(vld_w[0]), .sig_side_o(side_w[0]),
    .sig_price_o(price_w[0]), .sig_ready_i(ready), .overflow_o(ovf_w[0]),
`ifdef SMA_CROSS_STATS_EN
    .buy_count_o(buys_w[0]), .sell_count_o(sells_w[0]),
`endif
    .state_o(st_w[0]));

  sma_cross_signal #(.DATA_WIDTH(64), .WARMUP(4), .HYST(64'd2)) dut_h (
    .clk_i(clk), .reset_n_i(rst_n), .fast_avg_i(fast), .slow_avg_i(slow),
    .avg_valid_i(av), .sig_valid_o(vld_w[1]), .sig_side_o(side_w[1]),
    .sig_price_o(price_w[1]), .sig_ready_i(ready), .overflow_o(ovf_w[1]),
`ifdef SMA_CROSS_STATS_EN
    .buy_count_o(buys_w[1]), .sell_count_o(sells_w[1]),
`endif
    .state_o(st_w[1]));

  // Reference model: relation 0=warming 1=flat 2=above 3=below.
  typedef struct {
    int          rel;
    int          warm;
    bit          v;
    bit          side;
    logic [63:0] price;
    bit          ovf;
    int unsigned buys;
    int unsigned sells;
  } mdl_t;

  mdl_t m [2];
  localparam int MWARM = 4;
  int unsigned mhyst [2] = '{0, 2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].rel = 0; m[k].warm = 0; m[k].v = 0; m[k].side = 0;
      m[k].price = '0; m[k].ovf = 0; m[k].buys = 0; m[k].sells = 0;
    end
  endtask

  task automatic model_step(input int k);
    logic [64:0] f, s, h;
    bit go_up, go_dn, taken, fire, fire_side;
    f = {1'b0, fast};
    s = {1'b0, slow};
    h = 65'(mhyst[k]);
    go_up = f > s + h;
    go_dn = f + h < s;
    taken = m[k].v && ready;
    fire = 0;
    fire_side = 0;
    m[k].ovf = 0;
    if (taken) begin
      if (m[k].side) m[k].buys++;
      else           m[k].sells++;
    end
    if (av) begin
      if (m[k].rel == 0) begin
        m[k].warm++;
        if (m[k].warm >= MWARM) m[k].rel = 1;
      end else if (go_up && m[k].rel != 2) begin
        fire = (m[k].rel == 3);
        fire_side = 1;
        m[k].rel = 2;
      end else if (go_dn && m[k].rel != 3) begin
        fire = (m[k].rel == 2);
        fire_side = 0;
        m[k].rel = 3;
      end
    end
    if (fire) begin
      m[k].ovf = m[k].v && !taken;
      m[k].v = 1;
      m[k].side = fire_side;
      m[k].price = fast;
    end else if (taken) begin
      m[k].v = 0;
    end
  endtask

  task automatic compare_model(input int k);
    chk($sformatf("mdl_state%0d", k), 64'(st_w[k]), 64'(m[k].rel));
    chk($sformatf("mdl_valid%0d", k), 64'(vld_w[k]), 64'(m[k].v));
    chk($sformatf("mdl_ovf%0d", k), 64'(ovf_w[k]), 64'(m[k].ovf));
    if (m[k].v) begin
      chk($sformatf("mdl_side%0d", k), 64'(side_w[k]), 64'(m[k].side));
      chk($sformatf("mdl_price%0d", k), price_w[k], m[k].price);
    end
`ifdef SMA_CROSS_STATS_EN
    chk($sformatf("mdl_buys%0d", k), 64'(buys_w[k]), 64'(m[k].buys));
    chk($sformatf("mdl_sells%0d", k), 64'(sells_w[k]), 64'(m[k].sells));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
    compare_model(0);
    compare_model(1);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), 64'(vld_w[k]), 64'd0);
      chk($sformatf("rst_state%0d", k), 64'(st_w[k]), 64'd0);
      chk($sformatf("rst_side%0d", k), 64'(side_w[k]), 64'd0);
      chk($sformatf("rst_price%0d", k), price_w[k], 64'd0);
      chk($sformatf("rst_ovf%0d", k), 64'(ovf_w[k]), 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit a, input logic [63:0] f, input logic [63:0] s, input bit r);
    av = a; fast = f; slow = s; ready = r;
  endtask

  typedef struct packed {
    logic        av;
    logic [63:0] f;
    logic [63:0] s;
    logic        rdy;
    logic        ev;
    logic        es;
    logic [63:0] ep;
    logic        eo;
    logic [1:0]  est;
  } vec_t;

  function automatic vec_t mk(input bit a, input int f, input int s, input bit r,
                              input bit ev, input bit es, input int ep, input bit eo,
                              input int est);
    vec_t t;
    t.av = a; t.f = 64'(f); t.s = 64'(s); t.rdy = r;
    t.ev = ev; t.es = es; t.ep = 64'(ep); t.eo = eo; t.est = 2'(est);
    return t;
  endfunction

  vec_t tbl [17];
  localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    //            av  f   s  rdy ev es ep eo st
    tbl[0]  = mk(1, 10, 5, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 10, 5, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 10, 5, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 10, 5, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, 10, 5, 0, 0, 0, 0, 0, 2);
    tbl[5]  = mk(0,  3, 5, 0, 0, 0, 0, 0, 2);
    tbl[6]  = mk(1,  3, 5, 1, 1, 0, 3, 0, 3);
    tbl[7]  = mk(0,  3, 5, 1, 0, 0, 0, 0, 3);
    tbl[8]  = mk(1,  9, 5, 0, 1, 1, 9, 0, 2);
    tbl[9]  = mk(0,  9, 5, 0, 1, 1, 9, 0, 2);
    tbl[10] = mk(1,  4, 5, 0, 1, 0, 4, 1, 3);
    tbl[11] = mk(0,  4, 5, 0, 1, 0, 4, 0, 3);
    tbl[12] = mk(0,  4, 5, 1, 0, 0, 0, 0, 3);
    tbl[13] = mk(1,  6, 6, 0, 0, 0, 0, 0, 3);
    tbl[14] = mk(1,  7, 6, 1, 1, 1, 7, 0, 2);
    tbl[15] = mk(1,  5, 6, 1, 1, 0, 5, 0, 3);
    tbl[16] = mk(0,  5, 6, 1, 0, 0, 0, 0, 3);

    model_reset();
    do_reset();

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].av, tbl[i].f, tbl[i].s, tbl[i].rdy);
      tick();
      chk($sformatf("tbl%0d_state", i), 64'(st_w[0]), 64'(tbl[i].est));
      chk($sformatf("tbl%0d_valid", i), 64'(vld_w[0]), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_ovf", i), 64'(ovf_w[0]), 64'(tbl[i].eo));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_side", i), 64'(side_w[0]), 64'(tbl[i].es));
        chk($sformatf("tbl%0d_price", i), price_w[0], tbl[i].ep);
      end
    end
`ifdef SMA_CROSS_STATS_EN
    chk("tbl_buy_count", 64'(buys_w[0]), 64'd1);
    chk("tbl_sell_count", 64'(sells_w[0]), 64'd3);
`endif

    // Hysteresis band on the HYST=2 instance, then wide-value no-wrap and reset while pending.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'd2, 64'd5, 0);
      tick();
    end
    chk("hyst_warm_done", 64'(st_w[1]), 64'd1);
    drive(1, 64'd2, 64'd5, 0);
    tick();
    chk("hyst_below", 64'(st_w[1]), 64'd3);
    drive(1, 64'd7, 64'd5, 0);
    tick();
    chk("hyst_band_state", 64'(st_w[1]), 64'd3);
    chk("hyst_band_valid", 64'(vld_w[1]), 64'd0);
    drive(1, 64'd8, 64'd5, 0);
    tick();
    chk("hyst_buy_state", 64'(st_w[1]), 64'd2);
    chk("hyst_buy_valid", 64'(vld_w[1]), 64'd1);
    chk("hyst_buy_side", 64'(side_w[1]), 64'd1);
    chk("hyst_buy_price", price_w[1], 64'd8);
    drive(1, MAXV, MAXV - 64'd1, 0);
    tick();
    chk("nowrap_state", 64'(st_w[1]), 64'd2);
    chk("nowrap_valid", 64'(vld_w[1]), 64'd1);
    chk("nowrap_price", price_w[1], 64'd8);
    chk("nowrap_ovf", 64'(ovf_w[1]), 64'd0);
    drive(0, 64'd0, 64'd0, 0);
    do_reset();

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] base;
      if ($urandom_range(0, 9) == 0) base = MAXV - 64'd15;
      else                           base = 64'($urandom_range(0, 1000));
      drive($urandom_range(0, 9) < 7, base + 64'($urandom_range(0, 15)),
            base + 64'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
      tick();
      if ($urandom_range(0, 599) == 0) begin
        drive(0, 64'd0, 64'd0, 0);
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
